// File: rtl/rotary_quadrature_frontend.sv
// rotary_quadrature_frontend
//
// Conditions the raw A/B pins of one rotary encoder. Each pin goes through a 2-flop synchroniser
// and a run-length glitch filter. The filtered pair is then x4-decoded into single-cycle count
// events. A windowed edge-rate estimate and an illegal-transition pulse are also produced.
//
// Parameters:
//   FILTER_LEN    consecutive identical synchronised samples needed to move a filtered level (1..15)
//   SPEED_WINDOW  speed measurement window length in CLOCK cycles (2..2^20)
//
// Ports:
//   CLOCK         system clock, rising edge
//   RESET_N       asynchronous active-low reset
//   A, B          raw encoder channels, asynchronous to CLOCK
//   COUNT_ENABLE  one-cycle pulse per valid quadrature step
//   DIRECTION     1 = forward (A leads B), 0 = reverse; updated with COUNT_ENABLE, held otherwise
//   SPEED         valid steps seen in the last completed window, saturated at 15
//   ERROR         one-cycle pulse when both filtered channels change in the same cycle
module rotary_quadrature_frontend #(
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned SPEED_WINDOW = 50000
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       A,
    input  logic       B,
    output logic       COUNT_ENABLE,
    output logic       DIRECTION,
    output logic [3:0] SPEED,
    output logic       ERROR
);

    localparam int unsigned     WinW     = (SPEED_WINDOW > 1) ? $clog2(SPEED_WINDOW) : 1;
    localparam logic [3:0]      FiltLast = 4'(FILTER_LEN - 1);
    localparam logic [4:0]      InitLast = 5'(FILTER_LEN + 1);
    localparam logic [WinW-1:0] WinLast  = WinW'(SPEED_WINDOW - 1);

    localparam logic [0:0] StInit = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    // Channel vectors: bit 1 = A, bit 0 = B.
    logic [0:0]      state_q, state_d;
    logic [4:0]      init_cnt_q, init_cnt_d;
    logic [1:0]      pin_meta_q, pin_s_q;
    logic [1:0]      filt_q, filt_d, filt_prev_q;
    logic [1:0][3:0] run_cnt_q, run_cnt_d;
    logic [WinW-1:0] win_cnt_q;
    logic [7:0]      ev_cnt_q;

    logic [1:0] step;
    logic       step_valid, step_err, step_fwd;
    logic       win_term;
    logic [8:0] ev_total;

    // INIT lets the synchronisers flush and seeds the filters with the current pin levels, so
    // whatever position the encoder rests in at reset never decodes as a step.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == StInit) begin
            init_cnt_d = init_cnt_q + 5'd1;
            if (init_cnt_q == InitLast) begin
                state_d = StRun;
            end
        end
    end

    // A level moves only after FILTER_LEN consecutive samples that disagree with it.
    always_comb begin
        filt_d    = filt_q;
        run_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (state_q == StInit) begin
                filt_d[i] = pin_s_q[i];
            end else if (pin_s_q[i] != filt_q[i]) begin
                if (run_cnt_q[i] >= FiltLast) begin
                    filt_d[i] = pin_s_q[i];
                end else begin
                    run_cnt_d[i] = run_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Gray order 00 -> 10 -> 11 -> 01 is forward; for a one-bit step, forward <=> prev B != new A.
    assign step       = filt_prev_q ^ filt_q;
    assign step_valid = (state_q == StRun) && ((step == 2'b01) || (step == 2'b10));
    assign step_err   = (state_q == StRun) && (step == 2'b11);
    assign step_fwd   = filt_prev_q[0] ^ filt_q[1];

    // The closing window includes a pulse that is on the output during its terminal cycle.
    assign win_term = (win_cnt_q == WinLast);
    assign ev_total = {1'b0, ev_cnt_q} + {8'd0, COUNT_ENABLE};

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            pin_meta_q  <= '0;
            pin_s_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            pin_meta_q  <= {A, B};
            pin_s_q     <= pin_meta_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            run_cnt_q   <= run_cnt_d;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            COUNT_ENABLE <= 1'b0;
            DIRECTION    <= 1'b0;
            ERROR        <= 1'b0;
        end else begin
            COUNT_ENABLE <= step_valid;
            ERROR        <= step_err;
            if (step_valid) begin
                DIRECTION <= step_fwd;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            win_cnt_q <= '0;
            ev_cnt_q  <= '0;
            SPEED     <= '0;
        end else begin
            if (win_term) begin
                win_cnt_q <= '0;
                ev_cnt_q  <= '0;
                SPEED     <= (ev_total > 9'd15) ? 4'd15 : ev_total[3:0];
            end else begin
                win_cnt_q <= win_cnt_q + WinW'(1);
                if (COUNT_ENABLE && (ev_cnt_q != 8'd255)) begin
                    ev_cnt_q <= ev_cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rotary_quadrature_frontend.sv
// tb_rotary_quadrature_frontend
//
// Bench for rotary_quadrature_frontend with FILTER_LEN=4 and SPEED_WINDOW=100. A behavioural
// reference model, driven by the same pins, predicts every output on every cycle. Table rows and
// short hand-written sequences check pulse counts, direction, latency, glitch rejection, window
// boundaries and reset abort against fixed expected values.
module tb_rotary_quadrature_frontend;

    localparam int FL = 4;
    localparam int W  = 100;

    logic       CLOCK   = 1'b0;
    logic       RESET_N = 1'b1;
    logic       A       = 1'b1;
    logic       B       = 1'b1;
    logic       COUNT_ENABLE, DIRECTION, ERROR;
    logic [3:0] SPEED;

    rotary_quadrature_frontend #(
        .FILTER_LEN  (FL),
        .SPEED_WINDOW(W)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .A           (A),
        .B           (B),
        .COUNT_ENABLE(COUNT_ENABLE),
        .DIRECTION   (DIRECTION),
        .SPEED       (SPEED),
        .ERROR       (ERROR)
    );

    always #5 CLOCK = ~CLOCK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Pulse tallies kept from the sampled outputs.
    int ce_seen  = 0;
    int err_seen = 0;
    int fwd_seen = 0;

    // ------------------------------------------------------------------ reference model
    // Edges are numbered from reset release (first edge = 1). The synchronised sample used at
    // edge k is the pin value sampled at edge k-2. A filtered level flips once the last FL
    // synchronised samples all disagree with it. A level change at edge j shows up as an event
    // after edge j+1, classified by its distance around the Gray cycle.
    int model_k;
    bit ha[$], hb[$];
    bit sa_h[$], sb_h[$];
    bit lv_a[$], lv_b[$];
    int win_ev[int];
    bit exp_ce, exp_dir, exp_err;
    int exp_spd;

    function automatic int gpos(input bit a, input bit b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gval(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        model_k = 0;
        ha.delete(); hb.delete(); sa_h.delete(); sb_h.delete();
        lv_a.delete(); lv_b.delete();
        lv_a.push_back(1'b0); lv_b.push_back(1'b0);
        win_ev.delete();
        exp_ce = 0; exp_dir = 0; exp_err = 0; exp_spd = 0;
    endtask

    task automatic model_step(input bit a, input bit b);
        bit sa, sb, la, lb, flip_a, flip_b;
        int d, n;
        model_k++;
        ha.push_back(a); hb.push_back(b);
        sa = (model_k >= 3) ? ha[model_k-3] : 1'b0;
        sb = (model_k >= 3) ? hb[model_k-3] : 1'b0;
        sa_h.push_back(sa); sb_h.push_back(sb);
        la = lv_a[model_k-1];
        lb = lv_b[model_k-1];
        if (model_k <= FL + 2) begin
            la = sa;
            lb = sb;
        end else begin
            flip_a = 1; flip_b = 1;
            n = sa_h.size();
            for (int i = 0; i < FL; i++) begin
                if (sa_h[n-1-i] == la) flip_a = 0;
                if (sb_h[n-1-i] == lb) flip_b = 0;
            end
            if (flip_a) la = ~la;
            if (flip_b) lb = ~lb;
        end
        lv_a.push_back(la); lv_b.push_back(lb);
        exp_ce = 0; exp_err = 0;
        if (model_k >= FL + 3) begin
            d = (gpos(lv_a[model_k-1], lv_b[model_k-1]) - gpos(lv_a[model_k-2], lv_b[model_k-2]) + 4) % 4;
            if (d == 1 || d == 3) begin
                exp_ce  = 1;
                exp_dir = (d == 1);
            end
            if (d == 2) exp_err = 1;
        end
        if (exp_ce) win_ev[model_k / W] = (win_ev.exists(model_k / W) ? win_ev[model_k / W] : 0) + 1;
        if (model_k % W == 0) begin
            n = win_ev.exists(model_k / W - 1) ? win_ev[model_k / W - 1] : 0;
            exp_spd = (n > 15) ? 15 : n;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLOCK);
            if (!RESET_N) model_reset();
            else model_step(A, B);
        end
    end

    // Every cycle: DUT outputs against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (chk_en) begin
                n_tests++;
                if ({COUNT_ENABLE, DIRECTION, ERROR, SPEED} !== {exp_ce, exp_dir, exp_err, 4'(exp_spd)}) begin
                    n_fail++;
                    $display("FAIL model k=%0d: got ce=%b dir=%b err=%b speed=%0d, want ce=%b dir=%b err=%b speed=%0d",
                             model_k, COUNT_ENABLE, DIRECTION, ERROR, SPEED, exp_ce, exp_dir, exp_err, exp_spd);
                end
                if (COUNT_ENABLE) ce_seen++;
                if (COUNT_ENABLE && DIRECTION) fwd_seen++;
                if (ERROR) err_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------ helpers
    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic cyc();
        @(negedge CLOCK);
        #2;
    endtask

    task automatic wait_k(input int target);
        int n = 0;
        while (model_k < target && n < 5000) begin
            cyc();
            n++;
        end
        if (model_k != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_k: reached %0d, wanted %0d", model_k, target);
        end
    endtask

    int gp = 0;
    task automatic fwd_step();
        gp = (gp + 1) % 4;
        {A, B} = gval(gp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"}, COUNT_ENABLE, 0);
        check({tag, "_dir"}, DIRECTION, 0);
        check({tag, "_err"}, ERROR, 0);
        check({tag, "_speed"}, SPEED, 0);
    endtask

    typedef struct {
        logic a;
        logic b;
        int   ce;
        int   err;
        logic dir;
    } step_t;

    step_t tbl [17];

    // ------------------------------------------------------------------ main sequence
    initial begin
        int c0, e0, f0, lat;

        tbl = '{
            '{1'b1, 1'b1, 0, 0, 1'b0},  // static 11 after INIT
            '{1'b0, 1'b1, 1, 0, 1'b1},  // forward 11->01
            '{1'b0, 1'b0, 1, 0, 1'b1},
            '{1'b1, 1'b0, 1, 0, 1'b1},
            '{1'b1, 1'b1, 1, 0, 1'b1},
            '{1'b1, 1'b0, 1, 0, 1'b0},  // reverse 11->10
            '{1'b0, 1'b0, 1, 0, 1'b0},
            '{1'b0, 1'b1, 1, 0, 1'b0},
            '{1'b1, 1'b1, 1, 0, 1'b0},
            '{1'b1, 1'b0, 1, 0, 1'b0},
            '{1'b0, 1'b0, 1, 0, 1'b0},
            '{1'b0, 1'b1, 1, 0, 1'b0},
            '{1'b1, 1'b1, 1, 0, 1'b0},
            '{1'b1, 1'b0, 1, 0, 1'b0},
            '{1'b0, 1'b0, 1, 0, 1'b0},
            '{1'b1, 1'b1, 0, 1, 1'b0},  // both bits 00->11
            '{1'b0, 1'b0, 0, 1, 1'b0}   // both bits 11->00
        };

        // Reset with the encoder resting at 11.
        #3 RESET_N = 1'b0;
        #1 check_reset_outputs("reset");
        chk_en = 1'b1;
        repeat (3) cyc();
        RESET_N = 1'b1;
        repeat (30) cyc();

        foreach (tbl[i]) begin
            c0 = ce_seen; e0 = err_seen;
            A = tbl[i].a; B = tbl[i].b;
            repeat (20) cyc();
            check($sformatf("row%0d_ce", i), ce_seen - c0, tbl[i].ce);
            check($sformatf("row%0d_err", i), err_seen - e0, tbl[i].err);
            check($sformatf("row%0d_dir", i), DIRECTION, tbl[i].dir);
        end

        // Glitches on A while resting at 00.
        c0 = ce_seen;
        A = 1'b1; repeat (3) cyc(); A = 1'b0;
        repeat (20) cyc();
        check("glitch3_ce", ce_seen - c0, 0);

        c0 = ce_seen; f0 = fwd_seen;
        A = 1'b1; repeat (4) cyc(); A = 1'b0;
        repeat (20) cyc();
        check("glitch4_ce", ce_seen - c0, 2);
        check("glitch4_fwd", fwd_seen - f0, 1);
        check("glitch4_dir", DIRECTION, 0);

        // Pin edge to pulse latency.
        lat = 0;
        A = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (COUNT_ENABLE && lat == 0) lat = i;
        end
        check("latency", lat, 7);
        check("latency_dir", DIRECTION, 1);
        A = 1'b0;
        repeat (20) cyc();

        // Speed windows, aligned to a fresh reset.
        gp = 0; {A, B} = gval(gp);
        cyc();
        RESET_N = 1'b0;
        repeat (3) cyc();
        RESET_N = 1'b1;
        wait_k(10);
        for (int i = 0; i < 6; i++) begin
            fwd_step();
            repeat (10) cyc();
        end
        wait_k(99);
        check("speed_before_update", SPEED, 0);
        wait_k(100);
        check("speed_6", SPEED, 6);
        for (int i = 0; i < 40; i++) begin
            fwd_step();
            repeat (2) cyc();
        end
        wait_k(199);
        check("speed_6_held", SPEED, 6);
        wait_k(200);
        check("speed_sat", SPEED, 15);
        wait_k(300);
        check("speed_idle", SPEED, 0);
        wait_k(392);
        fwd_step();
        wait_k(399);
        check("terminal_pulse", COUNT_ENABLE, 1);
        wait_k(400);
        check("speed_terminal", SPEED, 1);
        wait_k(500);
        check("speed_after_terminal", SPEED, 0);

        // Random pin activity, including glitches and simultaneous toggles.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) A = ~A;
            else if (r < 8) B = ~B;
            else if (r == 8) begin A = ~A; B = ~B; end
            repeat ($urandom_range(1, 12)) cyc();
        end

        // Reset landing on a live pulse.
        {A, B} = 2'b00;
        repeat (30) cyc();
        A = 1'b1;
        repeat (7) cyc();
        check("pre_abort_ce", COUNT_ENABLE, 1);
        RESET_N = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) cyc();
        RESET_N = 1'b1;
        repeat (30) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
